// File: rtl/rename_dispatch_queue_if.sv
// Rename -> dispatch queue bus: enqueue group from rename, head window and dequeue count to dispatch.
interface rename_dispatch_queue_if #(
  parameter int ARF_WIDTH  = 5,
  parameter int PRF_WIDTH  = 6,
  parameter int DECODE_NUM = 4,
  parameter int CNT_WIDTH  = 5
);
  logic                            flush;
  logic [DECODE_NUM-1:0]           in_valid;
  logic [DECODE_NUM*ARF_WIDTH-1:0] in_rd;
  logic [DECODE_NUM*PRF_WIDTH-1:0] in_prd, in_prs1, in_prs2, in_preprd;
  logic [DECODE_NUM-1:0]           in_prs1_v, in_prs2_v, in_prd_v;
  logic                            in_ready;
  logic [DECODE_NUM-1:0]           out_valid;
  logic [DECODE_NUM*ARF_WIDTH-1:0] out_rd;
  logic [DECODE_NUM*PRF_WIDTH-1:0] out_prd, out_prs1, out_prs2, out_preprd;
  logic [DECODE_NUM-1:0]           out_prs1_v, out_prs2_v, out_prd_v;
  logic [2:0]                      deq_num;
  logic [CNT_WIDTH-1:0]            count;

  modport master (
    output flush, in_valid, in_rd, in_prd, in_prs1, in_prs2, in_preprd,
           in_prs1_v, in_prs2_v, in_prd_v, deq_num,
    input  in_ready, out_valid, out_rd, out_prd, out_prs1, out_prs2, out_preprd,
           out_prs1_v, out_prs2_v, out_prd_v, count
  );

  modport slave (
    input  flush, in_valid, in_rd, in_prd, in_prs1, in_prs2, in_preprd,
           in_prs1_v, in_prs2_v, in_prd_v, deq_num,
    output in_ready, out_valid, out_rd, out_prd, out_prs1, out_prs2, out_preprd,
           out_prs1_v, out_prs2_v, out_prd_v, count
  );
endinterface

// File: rtl/rename_dispatch_queue.sv
// Circular buffer between rename and dispatch: compacting 4-wide enqueue, in-order 4-wide head window.
module rename_dispatch_queue #(
  parameter int ARF_WIDTH  = 5,
  parameter int PRF_WIDTH  = 6,
  parameter int DECODE_NUM = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic clk,
  input  logic rst,
  rename_dispatch_queue_if.slave bus
);
  localparam int PTR_W = CNT_WIDTH - 1;

  typedef struct packed {
    logic [ARF_WIDTH-1:0] rd;
    logic [PRF_WIDTH-1:0] prd;
    logic [PRF_WIDTH-1:0] prs1;
    logic [PRF_WIDTH-1:0] prs2;
    logic [PRF_WIDTH-1:0] preprd;
    logic                 prs1_v;
    logic                 prs2_v;
    logic                 prd_v;
  } uop_t;

  uop_t                 r_mem [DEPTH];
  logic [PTR_W-1:0]     r_head, r_tail;
  logic [CNT_WIDTH-1:0] r_count;

  uop_t                 w_in  [DECODE_NUM];
  uop_t                 w_out [DECODE_NUM];
  logic [2:0]           w_off [DECODE_NUM];
  logic [2:0]           w_acc;
  logic [2:0]           w_enq_num;
  logic [2:0]           w_avail;
  logic [2:0]           w_eff_deq;
  logic                 w_in_ready;
  logic                 w_do_enq;

  assign w_in_ready = r_count <= CNT_WIDTH'(DEPTH - DECODE_NUM);
  assign w_do_enq   = w_in_ready && !bus.flush;

  // Unpack the input group; each valid slot's offset is the count of valid slots below it.
  always_comb begin
    w_in  = '{default: '0};
    w_off = '{default: '0};
    w_acc = '0;
    for (int unsigned i = 0; i < DECODE_NUM; i++) begin
      w_in[i].rd     = bus.in_rd[i*ARF_WIDTH +: ARF_WIDTH];
      w_in[i].prd    = bus.in_prd[i*PRF_WIDTH +: PRF_WIDTH];
      w_in[i].prs1   = bus.in_prs1[i*PRF_WIDTH +: PRF_WIDTH];
      w_in[i].prs2   = bus.in_prs2[i*PRF_WIDTH +: PRF_WIDTH];
      w_in[i].preprd = bus.in_preprd[i*PRF_WIDTH +: PRF_WIDTH];
      w_in[i].prs1_v = bus.in_prs1_v[i];
      w_in[i].prs2_v = bus.in_prs2_v[i];
      w_in[i].prd_v  = bus.in_prd_v[i];
      w_off[i]       = w_acc;
      w_acc          = w_acc + {2'b00, bus.in_valid[i]};
    end
  end

  assign w_enq_num = w_do_enq ? w_acc : 3'd0;
  assign w_avail   = (r_count >= CNT_WIDTH'(DECODE_NUM)) ? 3'(DECODE_NUM) : r_count[2:0];
  assign w_eff_deq = (bus.deq_num > w_avail) ? w_avail : bus.deq_num;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_eff_deq);
      r_tail  <= r_tail + PTR_W'(w_enq_num);
      r_count <= r_count + CNT_WIDTH'(w_enq_num) - CNT_WIDTH'(w_eff_deq);
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DECODE_NUM; i++) begin
      if (w_do_enq && bus.in_valid[i])
        r_mem[r_tail + PTR_W'(w_off[i])] <= w_in[i];
    end
  end

  always_comb begin
    bus.out_valid  = '0;
    bus.out_rd     = '0;
    bus.out_prd    = '0;
    bus.out_prs1   = '0;
    bus.out_prs2   = '0;
    bus.out_preprd = '0;
    bus.out_prs1_v = '0;
    bus.out_prs2_v = '0;
    bus.out_prd_v  = '0;
    w_out          = '{default: '0};
    for (int unsigned i = 0; i < DECODE_NUM; i++) begin
      w_out[i]                                = r_mem[r_head + PTR_W'(i)];
      bus.out_valid[i]                        = r_count > CNT_WIDTH'(i);
      bus.out_rd[i*ARF_WIDTH +: ARF_WIDTH]     = w_out[i].rd;
      bus.out_prd[i*PRF_WIDTH +: PRF_WIDTH]    = w_out[i].prd;
      bus.out_prs1[i*PRF_WIDTH +: PRF_WIDTH]   = w_out[i].prs1;
      bus.out_prs2[i*PRF_WIDTH +: PRF_WIDTH]   = w_out[i].prs2;
      bus.out_preprd[i*PRF_WIDTH +: PRF_WIDTH] = w_out[i].preprd;
      bus.out_prs1_v[i]                       = w_out[i].prs1_v;
      bus.out_prs2_v[i]                       = w_out[i].prs2_v;
      bus.out_prd_v[i]                        = w_out[i].prd_v;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.count    = r_count;
endmodule

// File: tb/tb_rename_dispatch_queue.sv
// Directed bench for rename_dispatch_queue: fill, full/no-credit, flush, clamp, wrap/compaction, async reset.
module tb_rename_dispatch_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rename_dispatch_queue_if #(.ARF_WIDTH(5), .PRF_WIDTH(6), .DECODE_NUM(4), .CNT_WIDTH(5)) bus ();

  rename_dispatch_queue #(
    .ARF_WIDTH(5), .PRF_WIDTH(6), .DECODE_NUM(4), .DEPTH(16), .CNT_WIDTH(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Slot i carries prd = base+i; other fields are fixed offsets of it.
  task automatic drive(input logic fl, input logic [3:0] vld, input int base, input int deq);
    bus.flush    = fl;
    bus.in_valid = vld;
    bus.deq_num  = 3'(deq);
    for (int i = 0; i < 4; i++) begin
      bus.in_rd[i*5 +: 5]     = 5'(base + i);
      bus.in_prd[i*6 +: 6]    = 6'(base + i);
      bus.in_prs1[i*6 +: 6]   = 6'(base + i + 16);
      bus.in_prs2[i*6 +: 6]   = 6'(base + i + 32);
      bus.in_preprd[i*6 +: 6] = 6'(base + i + 48);
    end
    bus.in_prs1_v = vld;
    bus.in_prs2_v = vld;
    bus.in_prd_v  = vld;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int prd_slot(input int i);
    logic [23:0] v;
    v = bus.out_prd;
    return int'(v[i*6 +: 6]);
  endfunction

  function automatic int rd_slot(input int i);
    logic [19:0] v;
    v = bus.out_rd;
    return int'(v[i*5 +: 5]);
  endfunction

  initial begin
    drive(1'b0, 4'h0, 0, 0);
    #1;
    check("rst_count", int'(bus.count), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b1;

    // Fill with four groups, prd 0..15
    for (int g = 0; g < 4; g++) begin
      drive(1'b0, 4'hF, g * 4, 0);
      cyc();
      check($sformatf("fill_count_%0d", g), int'(bus.count), (g + 1) * 4);
    end
    check("full_in_ready", int'(bus.in_ready), 0);
    check("full_out_valid", int'(bus.out_valid), 15);
    for (int i = 0; i < 4; i++) check($sformatf("full_prd_%0d", i), prd_slot(i), i);
    check("full_rd_2", rd_slot(2), 2);

    drive(1'b0, 4'hF, 40, 0);
    cyc();
    check("fifth_ignored_count", int'(bus.count), 16);
    check("fifth_ignored_prd0", prd_slot(0), 0);

    // Full with dequeue: no same-cycle credit
    drive(1'b0, 4'hF, 40, 4);
    cyc();
    check("full_deq_count", int'(bus.count), 12);
    check("full_deq_prd0", prd_slot(0), 4);
    check("full_deq_in_ready", int'(bus.in_ready), 1);

    drive(1'b0, 4'hF, 20, 4);
    cyc();
    check("enq_deq_count", int'(bus.count), 12);
    check("enq_deq_prd0", prd_slot(0), 8);
    check("enq_deq_prd3", prd_slot(3), 11);

    drive(1'b0, 4'h0, 0, 3);
    cyc();
    check("pre_flush_count", int'(bus.count), 9);
    check("pre_flush_prd0", prd_slot(0), 11);

    // Flush beats enqueue and dequeue; tail was 4, entry 4 must keep prd 4
    drive(1'b1, 4'hF, 50, 3);
    cyc();
    check("flush_count", int'(bus.count), 0);
    check("flush_out_valid", int'(bus.out_valid), 0);
    check("flush_head", int'(dut.r_head), 0);
    check("flush_tail", int'(dut.r_tail), 0);
    check("flush_no_write", int'(dut.r_mem[4].prd), 4);

    // Walk head to 12 with two live entries at 12,13
    drive(1'b0, 4'hF, 0, 0);
    cyc();
    drive(1'b0, 4'hF, 0, 4);
    cyc();
    drive(1'b0, 4'hF, 0, 4);
    cyc();
    drive(1'b0, 4'b0011, 30, 4);
    cyc();
    check("walk_count", int'(bus.count), 2);
    check("walk_prd0", prd_slot(0), 30);
    check("walk_prd1", prd_slot(1), 31);

    // Clamp: request 4 with only 2 present
    drive(1'b0, 4'h0, 0, 4);
    cyc();
    check("clamp_count", int'(bus.count), 0);
    check("clamp_head", int'(dut.r_head), 14);
    check("clamp_out_valid", int'(bus.out_valid), 0);

    // Wrap + compaction: 1011 with prd 10,11,12,13 -> entries 14,15,0 = 10,11,13
    drive(1'b0, 4'b1011, 10, 0);
    cyc();
    check("wrap_count", int'(bus.count), 3);
    check("wrap_out_valid", int'(bus.out_valid), 7);
    check("wrap_prd0", prd_slot(0), 10);
    check("wrap_prd1", prd_slot(1), 11);
    check("wrap_prd2", prd_slot(2), 13);
    check("wrap_rd2", rd_slot(2), 13);
    check("wrap_tail", int'(dut.r_tail), 1);

    drive(1'b0, 4'hF, 40, 1);
    cyc();
    check("wrap2_count", int'(bus.count), 6);
    check("wrap2_prd0", prd_slot(0), 11);
    check("wrap2_prd1", prd_slot(1), 13);
    check("wrap2_prd2", prd_slot(2), 40);
    check("wrap2_prd3", prd_slot(3), 41);

    drive(1'b0, 4'b0001, 60, 0);
    cyc();
    check("pre_rst_count", int'(bus.count), 7);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_count", int'(bus.count), 0);
    check("async_rst_out_valid", int'(bus.out_valid), 0);
    check("async_rst_in_ready", int'(bus.in_ready), 1);
    drive(1'b0, 4'h0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 4'hF, 5, 0);
    cyc();
    check("post_rst_count", int'(bus.count), 4);
    check("post_rst_prd0", prd_slot(0), 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
